// File: rtl/demux4_pkg.sv
// Shared types and constants for the four-way stream router.
// Optional delivery statistics are enabled by defining DEMUX4_STATS_EN.
package demux4_pkg;

  localparam int NCH    = 4;
  localparam int DEST_W = 2;
  localparam int CNT_W  = 8;

  typedef logic [DEST_W-1:0] dest_t;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_RR   = 1'b1
  } mode_e;

endpackage

// File: rtl/demux4_out_slot.sv
// One-entry holding slot for a single output lane with load/drain/full tracking.
// With DEMUX4_STATS_EN defined it also counts completed output handshakes.
module demux4_out_slot
  import demux4_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
`ifdef DEMUX4_STATS_EN
  ,
  output logic [CNT_W-1:0] o_count
`endif
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_drain;

  assign w_drain = r_valid && i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // A load wins over a drain so a slot can hand over and refill in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_load) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef DEMUX4_STATS_EN
  logic [CNT_W-1:0] r_count;

  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_drain && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/demux4_stream_router.sv
// Routes a single valid/ready stream to four lanes, addressed or round-robin.
// Define DEMUX4_STATS_EN to add the per-lane delivery counters on dlv_count.
module demux4_stream_router
  import demux4_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_dest,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic [NCH*W-1:0] out_data,
  output logic [1:0]       rr_ptr,
  output logic             busy
`ifdef DEMUX4_STATS_EN
  ,
  output logic [NCH*CNT_W-1:0] dlv_count
`endif
);

  dest_t r_ptr;
  dest_t w_dest;
  logic  w_accept;
  logic  w_rr;

  assign w_rr     = (mode_e'(mode) == MODE_RR);
  assign w_dest   = w_rr ? r_ptr : dest_t'(in_dest);
  // Only the targeted lane gates acceptance; the pointer never skips a full lane.
  assign in_ready = !out_valid[w_dest] || out_ready[w_dest];
  assign w_accept = in_valid && in_ready;
  assign rr_ptr   = r_ptr;
  assign busy     = |out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_accept && w_rr) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux4_out_slot #(
      .W(W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_accept && (w_dest == dest_t'(k))),
      .i_data  (in_data),
      .i_ready (out_ready[k]),
      .o_valid (out_valid[k]),
      .o_data  (out_data[k*W +: W])
`ifdef DEMUX4_STATS_EN
      ,
      .o_count (dlv_count[k*CNT_W +: CNT_W])
`endif
    );
  end

endmodule
